// File: rtl/mem_burst_ctrl.sv
// Burst controller between load/store logic and a single-port word RAM.
// Streams write beats into the RAM; returns read beats through a skid-free registered output.
module mem_burst_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beats_left;
  logic              capture;

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign wdata_ready = (state == WRITE);
  // Gated by state so a reset mid-burst kills the write strobe in the same cycle.
  assign ram_wr      = (state == WRITE) && wdata_valid;
  assign ram_addr    = cur_addr;
  assign ram_in      = wdata;
  // Refill whenever the output slot is empty or being drained this cycle.
  assign capture     = (state == READ) && (!rdata_valid || rdata_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_addr    <= '0;
      beats_left  <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            cur_addr   <= req_addr;
            beats_left <= req_len;
            state      <= req_we ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wdata_valid) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            if (beats_left == '0) state <= DONE;
            else beats_left <= beats_left - LEN_W'(1);
          end
        end
        READ: begin
          if (capture) begin
            rdata       <= ram_out;
            rdata_valid <= 1'b1;
            cur_addr    <= cur_addr + ADDR_W'(1);
            if (beats_left == '0) state <= DRAIN;
            else beats_left <= beats_left - LEN_W'(1);
          end
        end
        DRAIN: begin
          if (rdata_valid && rdata_ready) begin
            rdata_valid <= 1'b0;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a behavioural 256x32 RAM attached.
module tb_mem_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [3:0]  req_len;
  logic [31:0] wdata;
  logic        wdata_valid, wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid, rdata_ready;
  logic        busy, done;
  logic [7:0]  ram_addr;
  logic [31:0] ram_in, ram_out;
  logic        ram_wr;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_in;
  assign ram_out = mem[ram_addr];

  mem_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_in(ram_in), .ram_wr(ram_wr), .ram_out(ram_out)
  );

  task automatic test_reset();
    @(negedge clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0h exp 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0h exp 0", done); end
    vectors++; if (rdata_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %0h exp 0", rdata_valid); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %0h exp 0", rdata); end
    vectors++; if (ram_wr !== 1'b0) begin miscompares++; $display("FAIL reset_ramwr got %0h exp 0", ram_wr); end
    @(negedge clk); rst = 1'b0; #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rready got %0h exp 1", req_ready); end
  endtask

  task automatic test_write_burst();
    @(negedge clk); req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_len = 4'd3; #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL wr_accept got %0h exp 1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req_valid = 1'b0; wdata_valid = 1'b1; wdata = 32'(i + 1); #1;
      vectors++; if (ram_wr !== 1'b1) begin miscompares++; $display("FAIL wr_ramwr beat %0d got %0h exp 1", i, ram_wr); end
      vectors++; if (ram_addr !== 8'(8'h10 + i)) begin miscompares++; $display("FAIL wr_addr beat %0d got %0h exp %0h", i, ram_addr, 8'h10 + i); end
    end
    @(negedge clk); wdata_valid = 1'b0; #1;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wr_done got %0h exp 1", done); end
    vectors++; if (mem[8'h12] !== 32'd3) begin miscompares++; $display("FAIL wr_mem12 got %0h exp 3", mem[8'h12]); end
  endtask

  task automatic test_read_burst();
    @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_len = 4'd3; rdata_ready = 1'b1;
    @(negedge clk); req_valid = 1'b0; #1;
    vectors++; if (rdata_valid !== 1'b0) begin miscompares++; $display("FAIL rd_early_valid got %0h exp 0", rdata_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      vectors++; if (rdata_valid !== 1'b1) begin miscompares++; $display("FAIL rd_valid beat %0d got %0h exp 1", i, rdata_valid); end
      vectors++; if (rdata !== 32'(i + 1)) begin miscompares++; $display("FAIL rd_data beat %0d got %0h exp %0h", i, rdata, i + 1); end
    end
    @(negedge clk); #1;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rd_done got %0h exp 1", done); end
    vectors++; if (rdata_valid !== 1'b0) begin miscompares++; $display("FAIL rd_done_valid got %0h exp 0", rdata_valid); end
  endtask

  task automatic test_read_stall();
    logic        rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] dat [7] = '{32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd3, 32'd4};
    @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_len = 4'd3; rdata_ready = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); rdata_ready = rdy[k]; #1;
      vectors++; if (rdata_valid !== 1'b1 || rdata !== dat[k]) begin miscompares++; $display("FAIL stall_data cyc %0d got v=%0h d=%0h exp v=1 d=%0h", k, rdata_valid, rdata, dat[k]); end
    end
    @(negedge clk); #1;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL stall_done got %0h exp 1", done); end
  endtask

  task automatic test_wrap();
    logic [7:0] ea;
    @(negedge clk); req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hFE; req_len = 4'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req_valid = 1'b0; wdata_valid = 1'b1; wdata = 32'hA + 32'(i); #1;
      ea = 8'hFE + 8'(i);
      vectors++; if (ram_addr !== ea || ram_wr !== 1'b1) begin miscompares++; $display("FAIL wrap_wr beat %0d got a=%0h wr=%0h exp a=%0h wr=1", i, ram_addr, ram_wr, ea); end
    end
    @(negedge clk); wdata_valid = 1'b0; #1;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wrap_wr_done got %0h exp 1", done); end
    @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFE; req_len = 4'd3; rdata_ready = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      vectors++; if (rdata_valid !== 1'b1 || rdata !== 32'hA + 32'(i)) begin miscompares++; $display("FAIL wrap_rd beat %0d got v=%0h d=%0h exp v=1 d=%0h", i, rdata_valid, rdata, 32'hA + i); end
    end
    @(negedge clk); #1;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wrap_rd_done got %0h exp 1", done); end
  endtask

  task automatic test_len0_gap();
    @(negedge clk); req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_len = 4'd0; wdata_valid = 1'b0;
    @(negedge clk); req_valid = 1'b1; req_addr = 8'h40; #1;
    vectors++; if (ram_wr !== 1'b0 || req_ready !== 1'b0 || wdata_ready !== 1'b1) begin miscompares++; $display("FAIL gap1 got wr=%0h rr=%0h wrdy=%0h exp 0 0 1", ram_wr, req_ready, wdata_ready); end
    @(negedge clk); req_valid = 1'b0; #1;
    vectors++; if (ram_wr !== 1'b0) begin miscompares++; $display("FAIL gap2 got %0h exp 0", ram_wr); end
    @(negedge clk); wdata_valid = 1'b1; wdata = 32'h55; #1;
    vectors++; if (ram_wr !== 1'b1 || ram_addr !== 8'h20) begin miscompares++; $display("FAIL len0_write got wr=%0h a=%0h exp 1 20", ram_wr, ram_addr); end
    @(negedge clk); wdata_valid = 1'b0; #1;
    vectors++; if (done !== 1'b1 || req_ready !== 1'b0) begin miscompares++; $display("FAIL len0_done got d=%0h rr=%0h exp 1 0", done, req_ready); end
    @(negedge clk); #1;
    vectors++; if (busy !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL len0_idle got b=%0h rr=%0h exp 0 1", busy, req_ready); end
    vectors++; if (mem[8'h20] !== 32'h55) begin miscompares++; $display("FAIL len0_mem got %0h exp 55", mem[8'h20]); end
  endtask

  task automatic test_reset_midburst();
    @(negedge clk); req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_len = 4'd7;
    @(negedge clk); req_valid = 1'b0; wdata_valid = 1'b1; wdata = 32'h70;
    @(negedge clk); wdata = 32'h71;
    @(negedge clk); wdata = 32'h72; rst = 1'b1; #1;
    vectors++; if (ram_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort got wr=%0h b=%0h d=%0h exp 0 0 0", ram_wr, busy, done); end
    vectors++; if (rdata_valid !== 1'b0 || rdata !== 32'h0) begin miscompares++; $display("FAIL abort_rdata got v=%0h d=%0h exp 0 0", rdata_valid, rdata); end
    @(negedge clk); rst = 1'b0; wdata_valid = 1'b0; #1;
    vectors++; if (req_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle got rr=%0h b=%0h exp 1 0", req_ready, busy); end
    @(negedge clk); #1;
    vectors++; if (mem[8'h10] !== 32'h70 || mem[8'h11] !== 32'h71) begin miscompares++; $display("FAIL abort_kept got %0h %0h exp 70 71", mem[8'h10], mem[8'h11]); end
    vectors++; if (mem[8'h12] !== 32'd3 || mem[8'h13] !== 32'd4) begin miscompares++; $display("FAIL abort_untouched got %0h %0h exp 3 4", mem[8'h12], mem[8'h13]); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wdata = '0; wdata_valid = 1'b0; rdata_ready = 1'b0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_read_stall();
    test_wrap();
    test_len0_gap();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
